hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_if.sv | 40 ++++
 rtl/hazard_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: groups the decode-stage instruction fields fed to the hazard unit
// and the stall/forwarding controls it returns.
//   master: pipeline/control side (drives D-stage fields, receives controls)
//   slave : hazard unit side
//   d_rs/d_rt            source register fields of the instruction in D
//   d_tuse_rs/d_tuse_rt  cycles until D needs the source (0/1), 3 = not read
//   d_tnew               cycles until the D result exists (0/1/2), >2 = no write
//   d_wa                 destination register, 0 = no write
//   stall                freeze PC and F/D, bubble into E
//   fwd_d_*              D source select: 0 regfile, 1 E, 2 M, 3 W
//   fwd_e_*              E source select: 0 pipeline, 1 M, 2 W
//   fwd_m_rt             store data in M taken from W
//   stall_cnt            saturating count of stall cycles since reset
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic [1:0]       d_tuse_rs;
    logic [1:0]       d_tuse_rt;
    logic [2:0]       d_tnew;
    logic [4:0]       d_wa;
    logic             stall;
    logic [1:0]       fwd_d_rs;
    logic [1:0]       fwd_d_rt;
    logic [1:0]       fwd_e_rs;
    logic [1:0]       fwd_e_rt;
    logic             fwd_m_rt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_tnew, d_wa,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_tnew, d_wa,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: Tnew/Tuse hazard detection and forwarding control for a five-stage pipeline.
// Keeps a small scoreboard (wa, tnew, rs, rt) for the instructions in E, M and W.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, empties the scoreboard and the stall counter
//   hz    : hazard_unit_if slave port (D-stage fields in, stall/forwarding controls out)
module hazard_unit #(
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          reset,
    hazard_unit_if.slave hz
);

    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } entry_t;

    entry_t           e_q, m_q, w_q;
    entry_t           e_d, m_d, w_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall;

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // $0 is never a producer, so a zero wa can never match.
    function automatic logic hit(input logic [4:0] wa, input logic [4:0] src);
        return (wa != 5'd0) && (wa == src);
    endfunction

    function automatic logic src_stall(input logic [4:0] src, input logic [1:0] tuse,
                                       input entry_t e, input entry_t m);
        if (tuse == 2'd3) begin
            return 1'b0;
        end
        return (hit(e.wa, src) && (e.tnew > tuse)) || (hit(m.wa, src) && (m.tnew > tuse));
    endfunction

    // Only the youngest producer is a legal source; if it is not ready yet, the
    // stall logic holds D instead.
    function automatic logic [1:0] fwd_d_sel(input logic [4:0] src, input entry_t e,
                                             input entry_t m, input entry_t w);
        if (hit(e.wa, src)) begin
            return (e.tnew == 2'd0) ? 2'd1 : 2'd0;
        end
        if (hit(m.wa, src)) begin
            return (m.tnew == 2'd0) ? 2'd2 : 2'd0;
        end
        if (hit(w.wa, src)) begin
            return (w.tnew == 2'd0) ? 2'd3 : 2'd0;
        end
        return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [4:0] src, input entry_t m,
                                             input entry_t w);
        if (hit(m.wa, src) && (m.tnew == 2'd0)) begin
            return 2'd1;
        end
        if (hit(w.wa, src)) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    assign stall = src_stall(hz.d_rs, hz.d_tuse_rs, e_q, m_q)
                 | src_stall(hz.d_rt, hz.d_tuse_rt, e_q, m_q);

    always_comb begin
        e_d         = '0;
        m_d         = e_q;
        w_d         = m_q;
        stall_cnt_d = stall_cnt_q;
        m_d.tnew    = dec_sat(e_q.tnew);
        w_d.tnew    = dec_sat(m_q.tnew);
        // E keeps the full T code: a producer in E with T=2 must still stall a
        // reader with tuse=1, so the first decrement happens on the E->M move.
        if (!stall && (hz.d_tnew <= 3'd2)) begin
            e_d.wa   = hz.d_wa;
            e_d.tnew = hz.d_tnew[1:0];
        end
        if (!stall) begin
            e_d.rs = hz.d_rs;
            e_d.rt = hz.d_rt;
        end
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall     = stall;
    assign hz.fwd_d_rs  = fwd_d_sel(hz.d_rs, e_q, m_q, w_q);
    assign hz.fwd_d_rt  = fwd_d_sel(hz.d_rt, e_q, m_q, w_q);
    assign hz.fwd_e_rs  = fwd_e_sel(e_q.rs, m_q, w_q);
    assign hz.fwd_e_rt  = fwd_e_sel(e_q.rt, m_q, w_q);
    assign hz.fwd_m_rt  = hit(w_q.wa, m_q.rt);
    assign hz.stall_cnt = stall_cnt_q;

endmodule
